// File: rtl/axi_lite_master.sv
// AXI4-Lite master that runs one client command at a time (read or write) and returns a single response.
// It also keeps saturating counts of completed reads, completed writes and error responses.
module axi_lite_master (
    input  logic        aclk,
    input  logic        areset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,

    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count,

    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,

    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WRITE,
        WRESP,
        RSP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] err_count_q, err_count_d;
    logic        rd_inc, wr_inc, err_inc;

    // Address and write data come straight from the captured command, so they cannot move while a valid is up.
    assign m_axi_araddr = addr_q;
    assign m_axi_awaddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = 4'hF;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_resp     = rsp_resp_q;
    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
    assign err_count    = err_count_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rd_inc        = 1'b0;
        wr_inc        = 1'b0;
        err_inc       = 1'b0;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    state_d = cmd_write ? WRITE : RADDR;
                end
            end
            RADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rd_inc      = 1'b1;
                    err_inc     = (m_axi_rresp != RESP_OKAY);
                    state_d     = RSP;
                end
            end
            WRITE: begin
                // AW and W complete independently; leave as soon as both are done, whichever edge that is.
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                aw_done_d     = aw_done_q || m_axi_awready;
                w_done_d      = w_done_q || m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    rsp_rdata_d = 32'h0;
                    rsp_resp_d  = m_axi_bresp;
                    wr_inc      = 1'b1;
                    err_inc     = (m_axi_bresp != RESP_OKAY);
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_count_d  = (rd_inc && rd_count_q != CNT_MAX) ? rd_count_q + 16'd1 : rd_count_q;
        wr_count_d  = (wr_inc && wr_count_q != CNT_MAX) ? wr_count_q + 16'd1 : wr_count_q;
        err_count_d = (err_inc && err_count_q != CNT_MAX) ? err_count_q + 16'd1 : err_count_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_resp_q  <= 2'b00;
            rd_count_q  <= 16'h0;
            wr_count_q  <= 16'h0;
            err_count_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameters: none; address/data types are addr_t/data_t from axi_lite_pkg, both 32 bits.
REQ-002 aclk  input  1  clock, all logic on rising edge.
REQ-003 areset  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  client command valid.
REQ-005 cmd_ready  output  1  client command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  target address.
REQ-008 cmd_wdata  input  32  write data, ignored for reads.
REQ-009 rsp_valid  output  1  response valid.
REQ-010 rsp_ready  input  1  client accepts response.
REQ-011 rsp_rdata  output  32  read data, 0 for writes.
REQ-012 rsp_resp  output  2  captured RRESP/BRESP.
REQ-013 rd_count, wr_count, err_count  output  16 each  completed reads, completed writes, non-OKAY responses.
REQ-014 m_axi_lite  axi_lite_if.master  AR/R/AW/W/B channels driven toward the downstream axi_lite slave.

Function
REQ-015 States: IDLE, RADDR, RDATA, WRITE, WRESP, RSP; one command in flight at a time.
REQ-016 cmd_ready = 1 only in IDLE; on handshake, capture addr/wdata/write and go RADDR (read) or WRITE (write).
REQ-017 RADDR: arvalid = 1, araddr = captured addr, held stable until arvalid && arready, then go RDATA.
REQ-018 RDATA: rready = 1; on rvalid capture rdata into rsp_rdata, rresp into rsp_resp, go RSP.
REQ-019 WRITE: awvalid = !aw_done, wvalid = !w_done, awaddr/wdata held stable; aw_done/w_done set on respective handshakes.
REQ-020 WRITE exits to WRESP in the cycle both handshakes are complete, including AW and W on the same edge, or in either order.
REQ-021 WRESP: bready = 1; on bvalid capture bresp, force rsp_rdata = 0, go RSP; aw_done/w_done cleared.
REQ-022 RSP: rsp_valid = 1 with rsp_rdata/rsp_resp stable until rsp_ready; on rsp_ready go IDLE.
REQ-023 arvalid, awvalid, wvalid, rready, bready are 0 in every state other than those listed above.
REQ-024 No AXI valid is ever withdrawn before its handshake; addr/data never change while valid is high.
REQ-025 rd_count/wr_count increment by 1 on the R/B handshake; err_count increments when the captured resp != RESP_OKAY.
REQ-026 All counters saturate at 16'hFFFF; no wrap.
REQ-027 Latency with a zero-wait slave: rsp_valid asserts exactly 3 cycles after the read cmd handshake; write latency is set by the slave.
REQ-028 cmd_valid in non-IDLE states is ignored; no command is queued.

Reset
REQ-029 areset sampled high: state = IDLE next edge, all AXI valids/readies 0, cmd_ready 1, rsp_valid 0.
REQ-030 Reset clears rsp_rdata, rsp_resp, aw_done, w_done, and all counters to 0.
REQ-031 Reset mid-transaction abandons the transaction with no response; the first post-reset command behaves as a fresh transaction.

Verification
REQ-032 Write cmd addr 5, data 32'hDEADBEEF to the codebase slave, then read addr 5 -> read rsp_rdata 32'hDEADBEEF, rsp_resp OKAY, wr_count 1, rd_count 1.
REQ-033 Slave asserts awready 3 cycles after wready -> awaddr/wdata stable throughout, wvalid drops after W handshake, single WRESP, wr_count 1.
REQ-034 AW and W handshakes on the same edge -> WRESP next cycle, exactly one B handshake.
REQ-035 rsp_ready held low for 5 cycles -> rsp_valid/data stable for 5 cycles, cmd_ready 0 until the cycle after rsp_ready.
REQ-036 Slave returns rresp SLVERR -> rsp_resp 2'b10, err_count 1; preset err_count to 16'hFFFF, then another error -> stays 16'hFFFF.
REQ-037 areset pulsed while in RDATA -> next cycle rready 0, state IDLE, counters 0; subsequent read completes normally.
